// File: rtl/rpn_pkg.sv
// Shared types for the RPN pushbutton front end: debouncer FSM states and
// the pulse width expected by the RPN sequencer.
package rpn_pkg;

  typedef enum logic [1:0] {
    SOLTO          = 2'd0,
    CONFIRMA_PRESS = 2'd1,
    PRESSIONADO    = 2'd2,
    CONFIRMA_SOLTO = 2'd3
  } estado_botao_t;

  localparam int LARGURA_PULSO = 1;

endpackage

// File: rtl/debouncer_botao.sv
// One pushbutton: polarity normalization, 2-flop synchronizer and debounce FSM.
// Macro RPN_BOTAO_ATIVO_BAIXO_EN selects active-low raw inputs.
module debouncer_botao
  import rpn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic botao,
  output logic evento_press,
  output logic ativo
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          botao_norm;
  logic          sync1;
  logic          s;
  estado_botao_t estado;
  estado_botao_t estado_prox;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_prox;

`ifdef RPN_BOTAO_ATIVO_BAIXO_EN
  assign botao_norm = ~botao;
`else
  assign botao_norm = botao;
`endif

  // Two-flop synchronizer; reset value means "released" after normalization.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= botao_norm;
      s     <= sync1;
    end
  end

  always_comb begin
    estado_prox  = estado;
    cnt_prox     = cnt;
    evento_press = 1'b0;
    case (estado)
      SOLTO: begin
        if (s) begin
          estado_prox = CONFIRMA_PRESS;
          cnt_prox    = '0;
        end else begin
          estado_prox = SOLTO;
        end
      end
      CONFIRMA_PRESS: begin
        if (!s) begin
          estado_prox = SOLTO;
        end else if (cnt == CNT_MAX) begin
          estado_prox  = PRESSIONADO;
          evento_press = 1'b1;
        end else begin
          cnt_prox = cnt + 1'b1;
        end
      end
      PRESSIONADO: begin
        if (!s) begin
          estado_prox = CONFIRMA_SOLTO;
          cnt_prox    = '0;
        end else begin
          estado_prox = PRESSIONADO;
        end
      end
      CONFIRMA_SOLTO: begin
        // A return to pressed here is still the same press: no new event.
        if (s) begin
          estado_prox = PRESSIONADO;
        end else if (cnt == CNT_MAX) begin
          estado_prox = SOLTO;
        end else begin
          cnt_prox = cnt + 1'b1;
        end
      end
      default: begin
        estado_prox = SOLTO;
        cnt_prox    = '0;
      end
    endcase
  end

  // FSM state and confirmation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= SOLTO;
      cnt    <= '0;
    end else begin
      estado <= estado_prox;
      cnt    <= cnt_prox;
    end
  end

  assign ativo = (estado != SOLTO);

endmodule

// File: rtl/gerador_pulsos_rpn.sv
// ENTER/EXECUTAR pulse generator: two debouncers plus arbitration so the
// sequencer never sees both pulses at once. Macro: RPN_BOTAO_ATIVO_BAIXO_EN.
module gerador_pulsos_rpn
  import rpn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic botao_enter,
  input  logic botao_executar,
  output logic enter_pulso,
  output logic executar_pulso,
  output logic ocupado
);

  logic evento_enter;
  logic evento_executar;
  logic ativo_enter;
  logic ativo_executar;
  logic pend_executar;
  logic pend_enter;
  logic pend_executar_prox;
  logic pend_enter_prox;
  logic enter_prox;
  logic executar_prox;

  debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
    .clk          (clk),
    .reset        (reset),
    .botao        (botao_enter),
    .evento_press (evento_enter),
    .ativo        (ativo_enter)
  );

  debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_executar (
    .clk          (clk),
    .reset        (reset),
    .botao        (botao_executar),
    .evento_press (evento_executar),
    .ativo        (ativo_executar)
  );

  // Priority: pending EXECUTAR, then ENTER (new or deferred), then new EXECUTAR.
  always_comb begin
    enter_prox         = 1'b0;
    executar_prox      = 1'b0;
    pend_enter_prox    = 1'b0;
    pend_executar_prox = 1'b0;
    if (pend_executar) begin
      executar_prox      = 1'b1;
      pend_enter_prox    = evento_enter | pend_enter;
      pend_executar_prox = evento_executar;
    end else if (evento_enter || pend_enter) begin
      enter_prox         = 1'b1;
      pend_executar_prox = evento_executar;
    end else if (evento_executar) begin
      executar_prox = 1'b1;
    end else begin
      enter_prox    = 1'b0;
      executar_prox = 1'b0;
    end
  end

  // Registered pulses and pending flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      enter_pulso    <= 1'b0;
      executar_pulso <= 1'b0;
      pend_enter     <= 1'b0;
      pend_executar  <= 1'b0;
    end else begin
      enter_pulso    <= enter_prox;
      executar_pulso <= executar_prox;
      pend_enter     <= pend_enter_prox;
      pend_executar  <= pend_executar_prox;
    end
  end

  assign ocupado = ativo_enter | ativo_executar | pend_executar | pend_enter;

endmodule

// File: doc/gerador_pulsos_rpn.md
# gerador_pulsos_rpn

- Converts the two raw pushbutton inputs of the RPN calculator (ENTER and EXECUTAR) into clean, single-cycle pulses: `enter_pulso` and `executar_pulso`.
- Those pulses drive the RPN sequencer that loads registers A, B and Resultado.
- Each button is synchronized, debounced and edge-detected, so that one physical press produces exactly one pulse.
- Both sources are arbitrated so the sequencer never sees the two pulses in the same cycle.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a press or a release (10 ms at 50 MHz); legal range ≥ 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- botao_enter  input  1  raw ENTER button, asynchronous to clk; polarity per Configuration.
- botao_executar  input  1  raw EXECUTAR button, asynchronous to clk; polarity per Configuration.
- enter_pulso  output  1  one-cycle pulse per accepted ENTER press; registered.
- executar_pulso  output  1  one-cycle pulse per accepted EXECUTAR press; registered.
- ocupado  output  1  high while any button is not in SOLTO, or an EXECUTAR pulse is pending.

## Operation
- **Reset.** Sync flops go to 0 (released), FSMs go to SOLTO, counters to 0, the pending flag is cleared, and all outputs are 0.
- **Synchronizer.** Each input passes through a 2-flop synchronizer after polarity normalization; `s` = synced pressed level.
- **Per-button FSM** (counter width `$clog2(DEBOUNCE_CYCLES)`):
  - SOLTO: on `s`=1, go to CONFIRMA_PRESS with cnt=0.
  - CONFIRMA_PRESS: on `s`=0, return to SOLTO (bounce rejected, no pulse). If `s`=1 and cnt==DEBOUNCE_CYCLES-1, go to PRESSIONADO and raise the press event. Otherwise increment cnt.
  - PRESSIONADO: on `s`=0, go to CONFIRMA_SOLTO with cnt=0. No further events while the button is held; there is no auto-repeat.
  - CONFIRMA_SOLTO: on `s`=1, return to PRESSIONADO (no new pulse). If `s`=0 and cnt==DEBOUNCE_CYCLES-1, go to SOLTO. Otherwise increment cnt.
- **Arbitration.**
  - An ENTER event asserts `enter_pulso` for exactly 1 cycle.
  - An EXECUTAR event alone asserts `executar_pulso` for 1 cycle.
  - If both events occur in the same cycle, ENTER wins: `enter_pulso` is asserted, the pending flag is set, and `executar_pulso` is asserted the next cycle.
  - If a new ENTER event coincides with a pending EXECUTAR, the pending EXECUTAR is issued first and the ENTER is deferred 1 cycle. This cannot occur with DEBOUNCE_CYCLES ≥ 2 but must be handled.
  - Invariant: `enter_pulso & executar_pulso` is never 1.
- **Reset mid-operation.**
  - All in-flight confirmations are discarded and any pending pulse is dropped.
  - A button still held when reset deasserts is treated as a new press and yields one pulse after the full press latency.

## Timing
- **Press latency.** Raw press stable from cycle 0 → synced at cycle 2 → `enter_pulso`/`executar_pulso` high in cycle DEBOUNCE_CYCLES+3, for 1 cycle.
- **Release.** Release acceptance takes DEBOUNCE_CYCLES+3 cycles after the raw release and produces no output pulse.
- **Bounce rejection.** Any glitch shorter than DEBOUNCE_CYCLES synced cycles never produces a pulse.
- **Minimum spacing.** Minimum spacing between two pulses from the same button is 2·DEBOUNCE_CYCLES+2 cycles.
- **Deferred EXECUTAR.** When deferred by arbitration, `executar_pulso` lags by exactly 1 cycle.
- **`ocupado`.** Combinational from the registered state.

## Configuration
- RPN_BOTAO_ATIVO_BAIXO_EN defined: raw inputs are active-low (board KEY pins) and are inverted before the synchronizer.
- Undefined: raw inputs are active-high and used directly.
- Reset value of the sync flops is always "released" after normalization.

## Structure
- **Shared package `rpn_pkg`:**
  - enum `estado_botao_t` {SOLTO, CONFIRMA_PRESS, PRESSIONADO, CONFIRMA_SOLTO}, 2-bit.
  - Localparam for the sequencer-compatible pulse width (1).
- **Sub-module `debouncer_botao`** (parameter DEBOUNCE_CYCLES): synchronizer, FSM and counter, with a 1-cycle `evento_press` output. It is instantiated twice.
- **Top level:** arbitration, pending flag and output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Clean ENTER press held 20 cycles → exactly one `enter_pulso`, in cycle 7 after the raw edge; no pulse on release.
- ENTER bouncing 1-0-1-0 with 2-cycle periods, then stable → no pulse during bouncing; one pulse 7 cycles after the last rising edge.
- Both buttons pressed on the same cycle → `enter_pulso` at cycle 7, `executar_pulso` at cycle 8, never both high.
- EXECUTAR pressed, released after 10 cycles, pressed again after a 12-cycle gap → two `executar_pulso` pulses.
- Reset asserted in CONFIRMA_PRESS (cnt=2) with the button still held → no pulse during reset; one pulse 7 cycles after reset deasserts; all outputs 0 during reset.
- Build with and without RPN_BOTAO_ATIVO_BAIXO_EN; hold the input at 1 then 0 → a pulse occurs only for the configured pressed level.
